ccu_snoop_line_lock: RTL and testbench
======================================

// Module: ccu_snoop_line_lock
// PURPOSE
// - Line-granular conflict table in front of NumPorts parallel snoop controllers (read/write/extra
//   paths) of a multi-path CCU snoop path.
// - Admits at most one new coherent transaction per cycle. Blocks any request whose cache line
//   already has an in-flight transaction, so snoops to one line are serialised across paths.
// - Generalises the fixed one-read/one-write snoop path: any port count, configurable outstanding depth.
// PARAMETERS
// - NumPorts        2    requesting snoop controllers (>=1)
// - NumEntries      4    max in-flight lines (>=1)
// - AxiAddrWidth    64   request address width
// - DcacheLineWidth 512  line size in bits; OffW = $clog2(DcacheLineWidth/8)
// - SlotW derived: (NumEntries>1) ? $clog2(NumEntries) : 1
// PORTS
// - clk_i        in   1                 clock
// - rst_i        in   1                 reset: synchronous, active-high
// - req_valid_i  in   [NumPorts]        port requests admission (AR/AW valid of its controller)
// - req_addr_i   in   [NumPorts][Addr]  request address, stable while valid && !ready
// - req_ready_o  out  [NumPorts]        admission granted this cycle (onehot0)
// - req_slot_o   out  [NumPorts][SlotW] allocated slot, meaningful when valid && ready
// - rel_valid_i  in   [NumPorts]        port releases a slot (transaction fully complete)
// - rel_slot_i   in   [NumPorts][SlotW] slot to release
// - conflict_o   out  [NumPorts]        valid request blocked by a line match (perf/debug)
// - busy_o       out  [NumEntries]      registered entry-valid vector
// - full_o       out  1                 all entries valid (registered state)
// BEHAVIOUR
// - State: per entry valid bit + tag = addr[AxiAddrWidth-1:OffW]; rr_q pointer [NumPorts].
// - Reset: all valid=0, rr_q=0. While rst_i=1: req_ready_o=0, conflict_o=0, busy_o=0, full_o=0.
// - Reset mid-operation drops all entries. Owners are reset together; no release is expected afterwards.
// - Eligible(p) = req_valid_i[p] && !match(p) && !full_o.
//   - match(p) = any entry with valid_q && tag == req tag(p).
//   - Uses registered state only; no combinational path from rel_* to req_ready_o.
// - Grant: round-robin among eligible ports. Search starts at rr_q and wraps past NumPorts-1 to 0.
//   The first eligible port gets req_ready_o=1. Zero-cycle latency when eligible.
// - Two valid ports with the same line in one cycle: only one can be granted per cycle.
//   The other sees match next cycle and stays blocked.
// - Allocation: lowest-index free entry. req_slot_o of the granted port = that index.
//   The entry is valid with the tag from the next cycle.
//   req_slot_o of non-granted ports = 0.
// - rr_q <= (granted+1) mod NumPorts on a grant; unchanged otherwise.
// - Release: each rel_valid_i[p] clears entry rel_slot_i[p] at the next edge.
//   Multiple distinct releases in one cycle are all honoured. Duplicate slots are harmless.
//   Release of an already-free entry is ignored and flagged by assertion.
// - Release and grant in the same cycle: the released entry still blocks its line and still counts
//   as occupied this cycle. It is reusable/unblocked from the next cycle. Release→re-grant of same line >= 1 cycle.
// - Allocate and release of different entries in the same cycle: both take effect.
//   An entry never allocates and releases in the same cycle, because a free entry cannot be released legally.
// - conflict_o[p] = req_valid_i[p] && match(p). Not raised for full-only stalls.
// - full_o = &valid_q. busy_o = valid_q.
// - Assertions: req_addr_i stable while valid && !ready. valid never dropped before ready.
//   rel_slot_i < NumEntries. req_ready_o onehot0.
// STRUCTURE
// - ccu_pkg: function line_tag(addr) and localparam helpers for OffW/SlotW.
//   Shared with the snoop controllers, which must compute tags identically.
// - Sub-module ccu_line_lock_arb: NumPorts round-robin arbiter with synchronous active-high reset.
//   Inputs eligible vector; outputs onehot grant + index; owns rr_q.
// - Top holds the entry table, tag comparators (NumPorts x NumEntries), free-slot priority encoder and release logic.
// TESTING (NumPorts=2, NumEntries=4, 64B lines)
// - Basic admit/release:
//   - p0 req 0x1000 at cycle 1 → ready same cycle, slot 0; busy_o=0001 at cycle 2.
//   - p0 release slot 0 → busy_o=0000 next cycle.
// - Line conflict:
//   - slot 0 holds 0x1000; p1 req 0x1030 (same line) → ready=0, conflict_o[1]=1.
//   - Release slot 0 at cycle N → p1 ready at N+1 (not N), slot 0.
// - Arbitration fairness:
//   - p0=0x2000, p1=0x3000 held continuously from reset → p0 granted, then p1 the next cycle.
//   - Slots 0 then 1.
// - Same-line race: p0 and p1 both req 0x4000 in the same cycle.
//   - p0 granted (rr_q=0); p1 conflict from the next cycle until p0 releases.
// - Full + simultaneous events: fill 4 lines; p0 req new line → stalled, conflict_o=0.
//   - Release slot 2 while a new request arrives → grant one cycle later, slot 2.
// - Reset mid-operation: 3 entries busy, rst_i=1 for 1 cycle → busy_o=0, full_o=0, ready=0 during reset.
//   - The first request after reset gets slot 0.

Source files
------------

// File: rtl/ccu_pkg.sv
// Shared line-tag helpers for the CCU snoop path; the snoop controllers use the
// same functions so every agent derives an identical tag from an address.
package ccu_pkg;

  localparam int unsigned CcuMaxAddrW = 128;

  typedef logic [CcuMaxAddrW-1:0] ccu_addr_t;

  function automatic int unsigned off_w(input int unsigned line_bits);
    return $clog2(line_bits / 8);
  endfunction

  function automatic int unsigned slot_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic ccu_addr_t line_tag(input ccu_addr_t addr, input int unsigned shift);
    return addr >> shift;
  endfunction

endpackage

// File: rtl/ccu_line_lock_arb.sv
// Round-robin arbiter over the eligible ports; the search starts at rr_q and
// wraps, and rr_q moves one past the winner on every grant.
module ccu_line_lock_arb
  import ccu_pkg::*;
#(
  parameter int unsigned NumPorts = 2,
  localparam int unsigned IdxW = slot_w(NumPorts)
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic [NumPorts-1:0] eligible_i,
  output logic [NumPorts-1:0] grant_o,
  output logic [IdxW-1:0]     grant_idx_o,
  output logic                grant_valid_o
);

  logic [IdxW-1:0] rr_q;

  // Two passes: ports at or above rr_q first, then the wrapped-around ones.
  always_comb begin
    grant_o       = '0;
    grant_idx_o   = '0;
    grant_valid_o = 1'b0;
    for (int p = 0; p < NumPorts; p++) begin
      if (!grant_valid_o && eligible_i[p] && (IdxW'(p) >= rr_q)) begin
        grant_o[p]    = 1'b1;
        grant_idx_o   = IdxW'(p);
        grant_valid_o = 1'b1;
      end
    end
    for (int p = 0; p < NumPorts; p++) begin
      if (!grant_valid_o && eligible_i[p] && (IdxW'(p) < rr_q)) begin
        grant_o[p]    = 1'b1;
        grant_idx_o   = IdxW'(p);
        grant_valid_o = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rr_q <= '0;
    end else if (grant_valid_o) begin
      rr_q <= (grant_idx_o == IdxW'(NumPorts - 1)) ? '0 : grant_idx_o + IdxW'(1);
    end
  end

endmodule

// File: rtl/ccu_snoop_line_lock.sv
// Line-granular conflict table in front of the parallel snoop controllers:
// admits one new line per cycle and blocks requests to lines already in flight.
module ccu_snoop_line_lock
  import ccu_pkg::*;
#(
  parameter int unsigned NumPorts        = 2,
  parameter int unsigned NumEntries      = 4,
  parameter int unsigned AxiAddrWidth    = 64,
  parameter int unsigned DcacheLineWidth = 512,
  localparam int unsigned OffW  = off_w(DcacheLineWidth),
  localparam int unsigned SlotW = slot_w(NumEntries)
) (
  input  logic                                   clk_i,
  input  logic                                   rst_i,
  input  logic [NumPorts-1:0]                    req_valid_i,
  input  logic [NumPorts-1:0][AxiAddrWidth-1:0]  req_addr_i,
  output logic [NumPorts-1:0]                    req_ready_o,
  output logic [NumPorts-1:0][SlotW-1:0]         req_slot_o,
  input  logic [NumPorts-1:0]                    rel_valid_i,
  input  logic [NumPorts-1:0][SlotW-1:0]         rel_slot_i,
  output logic [NumPorts-1:0]                    conflict_o,
  output logic [NumEntries-1:0]                  busy_o,
  output logic                                   full_o
);

  localparam int unsigned TagW  = AxiAddrWidth - OffW;
  localparam int unsigned PortW = slot_w(NumPorts);

  logic [NumEntries-1:0]           valid_q;
  logic [NumEntries-1:0][TagW-1:0] tag_q;

  logic [NumPorts-1:0][TagW-1:0] req_tag;
  logic [NumPorts-1:0]           match;
  logic [NumPorts-1:0]           eligible;
  logic [NumPorts-1:0]           grant;
  logic [PortW-1:0]              grant_idx;
  logic                          grant_valid;
  logic [NumEntries-1:0]         rel_clr;
  logic [NumEntries-1:0]         alloc;
  logic [SlotW-1:0]              free_idx;
  logic                          full;

  // Matching only looks at registered entries, so a release this cycle still blocks.
  always_comb begin
    match = '0;
    for (int p = 0; p < NumPorts; p++) begin
      req_tag[p] = TagW'(line_tag(CcuMaxAddrW'(req_addr_i[p]), OffW));
      for (int e = 0; e < NumEntries; e++) begin
        if (valid_q[e] && (tag_q[e] == req_tag[p])) match[p] = 1'b1;
      end
    end
  end

  assign full     = &valid_q;
  assign eligible = rst_i ? '0 : (req_valid_i & ~match & {NumPorts{~full}});

  always_comb begin
    free_idx = '0;
    for (int e = int'(NumEntries) - 1; e >= 0; e--) begin
      if (!valid_q[e]) free_idx = SlotW'(e);
    end
  end

  always_comb begin
    rel_clr = '0;
    alloc   = '0;
    for (int e = 0; e < NumEntries; e++) begin
      alloc[e] = grant_valid && (free_idx == SlotW'(e));
      for (int p = 0; p < NumPorts; p++) begin
        if (rel_valid_i[p] && (rel_slot_i[p] == SlotW'(e))) rel_clr[e] = 1'b1;
      end
    end
  end

  ccu_line_lock_arb #(
    .NumPorts(NumPorts)
  ) u_arb (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .eligible_i   (eligible),
    .grant_o      (grant),
    .grant_idx_o  (grant_idx),
    .grant_valid_o(grant_valid)
  );

  always_comb begin
    for (int p = 0; p < NumPorts; p++) begin
      req_slot_o[p] = grant[p] ? free_idx : '0;
    end
  end

  assign req_ready_o = grant;
  assign conflict_o  = rst_i ? '0 : (req_valid_i & match);
  assign busy_o      = rst_i ? '0 : valid_q;
  assign full_o      = !rst_i && full;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      valid_q <= '0;
    end else begin
      valid_q <= (valid_q & ~rel_clr) | alloc;
    end
  end

  always_ff @(posedge clk_i) begin
    for (int e = 0; e < NumEntries; e++) begin
      if (alloc[e]) tag_q[e] <= req_tag[grant_idx];
    end
  end

`ifndef SYNTHESIS
  for (genvar p = 0; p < NumPorts; p++) begin : g_port_chk
    a_addr_stable: assert property (@(posedge clk_i) disable iff (rst_i)
      (req_valid_i[p] && !req_ready_o[p]) |=> $stable(req_addr_i[p]));
    a_valid_held: assert property (@(posedge clk_i) disable iff (rst_i)
      (req_valid_i[p] && !req_ready_o[p]) |=> req_valid_i[p]);
    a_rel_range: assert property (@(posedge clk_i) disable iff (rst_i)
      rel_valid_i[p] |-> (32'(rel_slot_i[p]) < NumEntries));
    a_rel_busy: assert property (@(posedge clk_i) disable iff (rst_i)
      (rel_valid_i[p] && (32'(rel_slot_i[p]) < NumEntries)) |-> valid_q[rel_slot_i[p]]);
  end
  a_ready_onehot0: assert property (@(posedge clk_i) $onehot0(req_ready_o));
`endif

endmodule

// File: tb/tb_ccu_snoop_line_lock.sv
// Bench for ccu_snoop_line_lock: directed scenarios then random traffic, all
// checked every cycle against a table-of-lines reference model.
module tb_ccu_snoop_line_lock;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             rst;
  logic [1:0]       rv;
  logic [1:0][63:0] ad;
  logic [1:0]       relv;
  logic [1:0][1:0]  rs;
  logic [1:0]       req_ready;
  logic [1:0][1:0]  req_slot;
  logic [1:0]       conflict;
  logic [3:0]       busy;
  logic             full;

  ccu_snoop_line_lock #(
    .NumPorts(2), .NumEntries(4), .AxiAddrWidth(64), .DcacheLineWidth(512)
  ) dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .req_valid_i(rv),
    .req_addr_i (ad),
    .req_ready_o(req_ready),
    .req_slot_o (req_slot),
    .rel_valid_i(relv),
    .rel_slot_i (rs),
    .conflict_o (conflict),
    .busy_o     (busy),
    .full_o     (full)
  );

  // reference: which lines are held, in which slot, and whose turn it is
  bit          mv[4];
  logic [57:0] mt[4];
  int          mrr;
  int          n_chk = 0;
  int          n_fail = 0;
  bit   [1:0]  xr;
  int          xs[2];
  logic [1:0]  sr, sc;
  logic [1:0]  ss[2];
  logic [3:0]  sb;
  logic        sf;
  bit          pend[2];
  int          owned[2][$];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    bit [1:0] er, ec;
    bit [3:0] eb;
    bit       ef, m0, m1;
    bit       m[2];
    int       g, fs, p;
    #1;
    er = '0; ec = '0; eb = '0; ef = 1'b0; g = -1; fs = -1;
    xs[0] = 0; xs[1] = 0;
    if (!rst) begin
      ef = 1'b1;
      for (int e = 0; e < 4; e++) begin
        eb[e] = mv[e];
        if (!mv[e]) ef = 1'b0;
        if (!mv[e] && fs < 0) fs = e;
      end
      for (int q = 0; q < 2; q++) begin
        m[q] = 1'b0;
        for (int e = 0; e < 4; e++) if (mv[e] && mt[e] == 58'(ad[q] >> 6)) m[q] = 1'b1;
        ec[q] = rv[q] && m[q];
      end
      for (int k = 0; k < 2; k++) begin
        p = (mrr + k) % 2;
        if (g < 0 && rv[p] && !m[p] && !ef) g = p;
      end
      if (g >= 0) begin
        er[g] = 1'b1;
        xs[g] = fs;
      end
    end
    m0 = 1'b0; m1 = m0;
    sr = req_ready; sc = conflict; sb = busy; sf = full;
    ss[0] = req_slot[0]; ss[1] = req_slot[1];
    chk("ready", 64'(req_ready), 64'(er));
    chk("conflict", 64'(conflict), 64'(ec));
    chk("busy", 64'(busy), 64'(eb));
    chk("full", 64'(full), 64'(ef));
    chk("slot0", 64'(req_slot[0]), 64'(xs[0]));
    chk("slot1", 64'(req_slot[1]), 64'(xs[1]));
    xr = er;
    if (rst) begin
      for (int e = 0; e < 4; e++) mv[e] = 1'b0;
      mrr = 0;
    end else begin
      for (int q = 0; q < 2; q++) if (relv[q]) mv[rs[q]] = 1'b0;
      if (g >= 0) begin
        mv[fs] = 1'b1;
        mt[fs] = 58'(ad[g] >> 6);
        mrr = (g + 1) % 2;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drv(input bit [1:0] v, input logic [63:0] a0, input logic [63:0] a1,
                     input bit [1:0] rl, input int r0, input int r1);
    rv = v; ad[0] = a0; ad[1] = a1; relv = rl; rs[0] = 2'(r0); rs[1] = 2'(r1);
    tick();
  endtask

  initial begin
    int k;
    rst = 1'b1; rv = '0; ad = '0; relv = '0; rs = '0;
    mrr = 0;
    for (int e = 0; e < 4; e++) begin mv[e] = 1'b0; mt[e] = '0; end
    tick();
    chk("rst_ready", 64'(sr), 64'h0);
    chk("rst_busy", 64'(sb), 64'h0);
    rst = 1'b0;

    // basic admit and release
    drv(2'b01, 64'h1000, 64'h0, 2'b00, 0, 0);
    chk("basic_ready", 64'(sr), 64'h1);
    chk("basic_slot", 64'(ss[0]), 64'h0);
    chk("basic_busy", 64'(busy), 64'h1);
    drv(2'b00, 64'h0, 64'h0, 2'b01, 0, 0);
    chk("basic_rel_busy", 64'(busy), 64'h0);

    // line conflict: release at N unblocks at N+1
    drv(2'b01, 64'h1000, 64'h0, 2'b00, 0, 0);
    drv(2'b10, 64'h0, 64'h1030, 2'b00, 0, 0);
    chk("conf_ready", 64'(sr), 64'h0);
    chk("conf_flag", 64'(sc), 64'h2);
    drv(2'b10, 64'h0, 64'h1030, 2'b01, 0, 0);
    chk("conf_rel_cycle_ready", 64'(sr), 64'h0);
    drv(2'b10, 64'h0, 64'h1030, 2'b00, 0, 0);
    chk("conf_next_ready", 64'(sr), 64'h2);
    chk("conf_next_slot", 64'(ss[1]), 64'h0);
    drv(2'b00, 64'h0, 64'h0, 2'b10, 0, 0);

    // fairness from reset
    rst = 1'b1;
    drv(2'b00, 64'h0, 64'h0, 2'b00, 0, 0);
    rst = 1'b0;
    drv(2'b11, 64'h2000, 64'h3000, 2'b00, 0, 0);
    chk("fair_first", 64'(sr), 64'h1);
    chk("fair_first_slot", 64'(ss[0]), 64'h0);
    drv(2'b10, 64'h0, 64'h3000, 2'b00, 0, 0);
    chk("fair_second", 64'(sr), 64'h2);
    chk("fair_second_slot", 64'(ss[1]), 64'h1);
    drv(2'b00, 64'h0, 64'h0, 2'b11, 0, 1);

    // same-line race
    drv(2'b11, 64'h4000, 64'h4000, 2'b00, 0, 0);
    chk("race_ready", 64'(sr), 64'h1);
    chk("race_conf0", 64'(sc), 64'h0);
    drv(2'b10, 64'h0, 64'h4000, 2'b00, 0, 0);
    chk("race_conf1", 64'(sc), 64'h2);
    drv(2'b10, 64'h0, 64'h4000, 2'b01, 0, 0);
    chk("race_conf_rel", 64'(sc), 64'h2);
    drv(2'b10, 64'h0, 64'h4000, 2'b00, 0, 0);
    chk("race_p1_ready", 64'(sr), 64'h2);
    drv(2'b00, 64'h0, 64'h0, 2'b10, 0, 0);

    // full table
    for (int i = 0; i < 4; i++) begin
      drv(2'b01, 64'h5000 + 64'(i) * 64, 64'h0, 2'b00, 0, 0);
      chk("fill_slot", 64'(ss[0]), 64'(i));
    end
    drv(2'b01, 64'h6000, 64'h0, 2'b00, 0, 0);
    chk("full_stall", 64'(sr), 64'h0);
    chk("full_noconf", 64'(sc), 64'h0);
    chk("full_flag", 64'(sf), 64'h1);
    drv(2'b01, 64'h6000, 64'h0, 2'b10, 0, 2);
    chk("full_rel_cycle", 64'(sr), 64'h0);
    drv(2'b01, 64'h6000, 64'h0, 2'b00, 0, 0);
    chk("full_regrant", 64'(sr), 64'h1);
    chk("full_regrant_slot", 64'(ss[0]), 64'h2);

    // reset mid-operation
    drv(2'b00, 64'h0, 64'h0, 2'b01, 3, 0);
    chk("mid_busy", 64'(busy), 64'h7);
    rst = 1'b1;
    drv(2'b01, 64'h8000, 64'h0, 2'b00, 0, 0);
    chk("mid_rst_ready", 64'(sr), 64'h0);
    chk("mid_rst_busy", 64'(sb), 64'h0);
    chk("mid_rst_full", 64'(sf), 64'h0);
    rst = 1'b0;
    drv(2'b01, 64'h8000, 64'h0, 2'b00, 0, 0);
    chk("post_rst_slot", 64'(ss[0]), 64'h0);
    chk("post_rst_ready", 64'(sr), 64'h1);
    rst = 1'b1;
    drv(2'b00, 64'h0, 64'h0, 2'b00, 0, 0);
    rst = 1'b0;

    // random traffic over eight lines, requests held until granted
    pend[0] = 1'b0; pend[1] = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      relv = '0;
      if ($urandom_range(0, 149) == 0) begin
        rst = 1'b1;
        pend[0] = 1'b0; pend[1] = 1'b0;
        owned[0].delete(); owned[1].delete();
      end else begin
        rst = 1'b0;
      end
      for (int p = 0; p < 2; p++) begin
        if (!rst && !pend[p] && $urandom_range(0, 1) == 1) begin
          pend[p] = 1'b1;
          ad[p] = 64'h1000 + 64'($urandom_range(0, 7)) * 64 + 64'($urandom_range(0, 63));
        end
        rv[p] = pend[p];
        if (!rst && owned[p].size() > 0 && $urandom_range(0, 3) == 0) begin
          k = $urandom_range(0, owned[p].size() - 1);
          relv[p] = 1'b1;
          rs[p] = 2'(owned[p][k]);
          owned[p].delete(k);
        end
      end
      tick();
      for (int p = 0; p < 2; p++) begin
        if (xr[p]) begin
          pend[p] = 1'b0;
          owned[p].push_back(xs[p]);
        end
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
